ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
Stage directly downstream of the PS/2 frame receiver. It consumes validated Set-2 scan-code bytes and folds the E0 (extended) and F0 (break) prefixes into single key events. Events are classified as digit (main row or keypad) or Enter, and buffered in a small FIFO with a valid/ready handshake. The calculator/display logic pops events instead of pattern-matching raw bytes.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
TIMEOUT_CYCLES, 50000, clock cycles a prefix state may wait for its next byte before abandoning (1 ms at 50 MHz)

Ports:
clock  input  1  system clock
reset_neg  input  1  asynchronous, active-low reset
rx_byte  input  8  scan-code byte from receiver, valid only with rx_valid
rx_valid  input  1  one-cycle strobe, byte accepted unconditionally
rx_error  input  1  one-cycle strobe, receiver framing/parity error
ev_valid  output  1  FIFO head holds an event
ev_ready  input  1  consumer accepts head when ev_valid=1
ev_code  output  8  base scan code (prefixes stripped)
ev_break  output  1  1 = key release, 0 = key press
ev_extended  output  1  event was E0-prefixed
ev_is_digit  output  1  ev_digit is meaningful
ev_digit  output  4  0..9, 0 when ev_is_digit=0
ev_is_enter  output  1  5A or E0 5A
fifo_count  output  $clog2(DEPTH)+1  entries held
overflow_sticky  output  1  an event was dropped on full FIFO
clear_overflow  input  1  synchronous clear of overflow_sticky

Behaviour:
- Reset: prefix FSM to IDLE, FIFO empty, ev_valid=0, all ev_* fields 0, fifo_count=0, overflow_sticky=0, timeout counter 0.
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on rx_valid.
  - IDLE: E0->GOT_E0; F0->GOT_F0; other byte -> emit make (ext=0), stay IDLE.
  - GOT_E0: F0->GOT_E0F0; E0->stay; other -> emit make (ext=1), ->IDLE.
  - GOT_F0: F0->stay; E0->GOT_E0F0; other -> emit break (ext=0), ->IDLE.
  - GOT_E0F0: E0/F0 -> discard, ->IDLE; other -> emit break (ext=1), ->IDLE.
- Byte E1 (Pause sequence) is never emitted. While in IDLE it is ignored; any E1-sequence bytes that follow pass through the normal rules.
- rx_error: FSM forced to IDLE, no event emitted, and a simultaneous rx_valid is ignored. rx_error has priority over rx_valid.
- Timeout: counter clears on every rx_valid and increments while the FSM is not in IDLE. On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no event.
- Classification is combinational on the base code at emit time. The classified result is stored in the FIFO entry.
  - Main-row digits (ext=0): 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Keypad digits (ext=0): 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - Digit codes with ext=1 are not digits.
  - Enter: code 5A, ext either value.
- Latency: rx_valid completing an event at cycle N -> ev_valid=1 at N+1 when the FIFO was empty. The head is registered, with no combinational rx->ev path.
- Handshake: pop when ev_valid & ev_ready. ev_* fields are held stable while ev_valid=1 and not popped. ev_ready is ignored when empty.
- Full: push with fifo_count=DEPTH and no pop in the same cycle -> event dropped, overflow_sticky=1, FIFO contents unchanged.
- Simultaneous push and pop when full: both happen, count unchanged, no overflow.
- Simultaneous push and pop when empty: push stored, ev_valid=1 next cycle.
- Pointers wrap modulo DEPTH. fifo_count is exact.
- clear_overflow and an overflow in the same cycle: overflow_sticky stays 1 (set wins).
- Reset mid-sequence (e.g. after E0): all state lost, next byte decoded from IDLE.

Decomposition:
- ps2_pkg holds:
  - prefix constants (PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_ENTER=8'h5A)
  - prefix-FSM state enum
  - packed struct ps2_event_t {code, brk, ext, is_digit, digit, is_enter}
  - the classify function
- Sub-module ps2_event_fifo: parameterised DEPTH, stores ps2_event_t, and provides push/pop/count/full/empty.

Test Plan:
- Bytes 16, F0, 16 -> two events: {code=16, brk=0, ext=0, digit=1} then {code=16, brk=1, digit=1}; each ev_valid one cycle after its final byte.
- Bytes E0, 5A, E0, F0, 5A -> {5A, brk=0, ext=1, is_enter=1}, then {5A, brk=1, ext=1, is_enter=1}; E0 70 gives is_digit=0.
- ev_ready held 0, six make codes 45, 16, 1E, 26, 25, 2E (DEPTH=4) -> fifo_count=4, overflow_sticky=1; pops return digits 0,1,2,3 in order. Pulse clear_overflow -> overflow_sticky=0.
- Byte F0, then rx_error pulse, then 3E -> single make event {3E, brk=0, digit=8}; separately, F0 followed by TIMEOUT_CYCLES idle cycles then 3E -> make, not break.
- FIFO full with ev_ready=1 and rx_valid on a completing byte in the same cycle -> count stays 4, no overflow, new event at tail.
- reset_neg asserted between E0 and 75 -> all outputs 0; after release, 75 alone -> {75, ext=0, is_digit=1, digit=8}.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 Set-2 prefix constants, event record and key classification.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ENTER = 8'h5A;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} prefix_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       is_digit;
    logic [3:0] digit;
    logic       is_enter;
  } ps2_event_t;

  // Main-row and keypad digits share one table; an E0 prefix disqualifies both.
  function automatic ps2_event_t classify(input logic [7:0] code, input logic brk, input logic ext);
    ps2_event_t ev;
    logic [4:0] hit_digit;
    case (code)
      8'h45, 8'h70: hit_digit = {1'b1, 4'd0};
      8'h16, 8'h69: hit_digit = {1'b1, 4'd1};
      8'h1E, 8'h72: hit_digit = {1'b1, 4'd2};
      8'h26, 8'h7A: hit_digit = {1'b1, 4'd3};
      8'h25, 8'h6B: hit_digit = {1'b1, 4'd4};
      8'h2E, 8'h73: hit_digit = {1'b1, 4'd5};
      8'h36, 8'h74: hit_digit = {1'b1, 4'd6};
      8'h3D, 8'h6C: hit_digit = {1'b1, 4'd7};
      8'h3E, 8'h75: hit_digit = {1'b1, 4'd8};
      8'h46, 8'h7D: hit_digit = {1'b1, 4'd9};
      default:      hit_digit = 5'd0;
    endcase
    ev.code     = code;
    ev.brk      = brk;
    ev.ext      = ext;
    ev.is_digit = hit_digit[4] & ~ext;
    ev.digit    = ev.is_digit ? hit_digit[3:0] : 4'd0;
    ev.is_enter = code == PS2_ENTER;
    return ev;
  endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: receiver-byte input and key-event output bundle of the decoder.
interface ps2_scancode_decoder_if #(parameter int DEPTH = 4);
  logic [7:0]             rx_byte;
  logic                   rx_valid;
  logic                   rx_error;
  logic                   ev_valid;
  logic                   ev_ready;
  logic [7:0]             ev_code;
  logic                   ev_break;
  logic                   ev_extended;
  logic                   ev_is_digit;
  logic [3:0]             ev_digit;
  logic                   ev_is_enter;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow_sticky;
  logic                   clear_overflow;

  modport master (
    output rx_byte, rx_valid, rx_error, ev_ready, clear_overflow,
    input  ev_valid, ev_code, ev_break, ev_extended, ev_is_digit, ev_digit, ev_is_enter,
           fifo_count, overflow_sticky
  );

  modport slave (
    input  rx_byte, rx_valid, rx_error, ev_ready, clear_overflow,
    output ev_valid, ev_code, ev_break, ev_extended, ev_is_digit, ev_digit, ev_is_enter,
           fifo_count, overflow_sticky
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: power-of-two FIFO of classified key events with exact occupancy count.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_neg,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  ps2_event_t             data_i,
  output ps2_event_t             data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  ps2_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = count_q == '0;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds E0/F0 prefixes of Set-2 scan codes into classified key events
// and queues them behind a valid/ready handshake.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                  clock,
  input logic                  reset_neg,
  ps2_scancode_decoder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  prefix_state_e          state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   is_e0, is_f0, is_e1;
  logic                   push, pop, full, empty;
  logic [$clog2(DEPTH):0] count;
  ps2_event_t             push_ev, head_ev;

  assign is_e0 = bus.rx_byte == PS2_EXT;
  assign is_f0 = bus.rx_byte == PS2_BRK;
  assign is_e1 = bus.rx_byte == PS2_PAUSE;
  // Any non-prefix byte completes an event from every state; E1 is never reported.
  assign push  = bus.rx_valid & ~bus.rx_error & ~is_e0 & ~is_f0 & ~is_e1;
  assign push_ev = classify(bus.rx_byte,
                            state_q == GOT_F0 || state_q == GOT_E0F0,
                            state_q == GOT_E0 || state_q == GOT_E0F0);
  assign pop   = bus.ev_ready & ~empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == IDLE ? '0 : cnt_q + CW'(1);
    ovf_d   = (push & full & ~pop) ? 1'b1 : bus.clear_overflow ? 1'b0 : ovf_q;
    if (bus.rx_error) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.rx_valid) begin
      cnt_d = '0;
      case (state_q)
        IDLE:    state_d = is_e0 ? GOT_E0 : is_f0 ? GOT_F0 : IDLE;
        GOT_E0:  state_d = is_f0 ? GOT_E0F0 : is_e0 ? GOT_E0 : IDLE;
        GOT_F0:  state_d = is_e0 ? GOT_E0F0 : is_f0 ? GOT_F0 : IDLE;
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset_neg(reset_neg),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (push_ev),
    .data_o   (head_ev),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign bus.ev_valid        = ~empty;
  assign bus.ev_code         = head_ev.code;
  assign bus.ev_break        = head_ev.brk;
  assign bus.ev_extended     = head_ev.ext;
  assign bus.ev_is_digit     = head_ev.is_digit;
  assign bus.ev_digit        = head_ev.digit;
  assign bus.ev_is_enter     = head_ev.is_enter;
  assign bus.fifo_count      = count;
  assign bus.overflow_sticky = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed byte sequences with hand-computed key events.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;
  localparam int TO    = 20;

  logic clock = 1'b0;
  logic reset_neg = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ps2_scancode_decoder_if #(.DEPTH(DEPTH)) bus ();

  ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock    (clock),
    .reset_neg(reset_neg),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head();
    return {15'd0, bus.ev_valid, bus.ev_code, bus.ev_break, bus.ev_extended,
            bus.ev_is_digit, bus.ev_digit, bus.ev_is_enter};
  endfunction

  function automatic logic [31:0] ev(input logic [7:0] code, input logic brk, input logic ext,
                                     input logic isd, input logic [3:0] dig, input logic ent);
    return {15'd0, 1'b1, code, brk, ext, isd, dig, ent};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pop();
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;
  endtask

  initial begin
    bus.rx_byte = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
    bus.ev_ready = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (2) tick();
    chk("reset_head", head(), 32'd0);
    chk("reset_count", 32'(bus.fifo_count), 32'd0);
    chk("reset_ovf", 32'(bus.overflow_sticky), 32'd0);
    reset_neg = 1'b1;
    tick();

    send(8'h16);
    chk("make_16", head(), ev(8'h16, 0, 0, 1, 4'd1, 0));
    pop();
    chk("count_after_pop", 32'(bus.fifo_count), 32'd0);
    send(8'hF0);
    chk("f0_no_event", 32'(bus.ev_valid), 32'd0);
    send(8'h16);
    chk("break_16", head(), ev(8'h16, 1, 0, 1, 4'd1, 0));
    pop();

    send(8'hE0);
    send(8'h5A);
    chk("make_e0_5a", head(), ev(8'h5A, 0, 1, 0, 4'd0, 1));
    pop();
    send(8'hE0);
    send(8'hF0);
    send(8'h5A);
    chk("break_e0_5a", head(), ev(8'h5A, 1, 1, 0, 4'd0, 1));
    pop();
    send(8'hE0);
    send(8'h70);
    chk("ext_70_not_digit", head(), ev(8'h70, 0, 1, 0, 4'd0, 0));
    pop();
    send(8'h7D);
    chk("keypad_9", head(), ev(8'h7D, 0, 0, 1, 4'd9, 0));
    pop();

    send(8'h45);
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    chk("full_no_ovf", 32'(bus.overflow_sticky), 32'd0);
    send(8'h25);
    send(8'h2E);
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_ovf", 32'(bus.overflow_sticky), 32'd1);
    chk("pop0", head(), ev(8'h45, 0, 0, 1, 4'd0, 0));
    pop();
    chk("pop1", head(), ev(8'h16, 0, 0, 1, 4'd1, 0));
    pop();
    chk("pop2", head(), ev(8'h1E, 0, 0, 1, 4'd2, 0));
    pop();
    chk("pop3", head(), ev(8'h26, 0, 0, 1, 4'd3, 0));
    pop();
    chk("drained", 32'(bus.fifo_count), 32'd0);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow_sticky), 32'd0);

    send(8'hF0);
    bus.rx_error = 1'b1;
    tick();
    bus.rx_error = 1'b0;
    send(8'h3E);
    chk("error_cancels_f0", head(), ev(8'h3E, 0, 0, 1, 4'd8, 0));
    pop();
    send(8'hF0);
    bus.rx_error = 1'b1;
    bus.rx_byte = 8'h16;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_error = 1'b0;
    bus.rx_valid = 1'b0;
    chk("error_beats_valid", 32'(bus.ev_valid), 32'd0);
    send(8'hF0);
    repeat (TO - 1) @(posedge clock);
    #1;
    send(8'h3E);
    chk("before_timeout", head(), ev(8'h3E, 1, 0, 1, 4'd8, 0));
    pop();
    send(8'hF0);
    repeat (TO) @(posedge clock);
    #1;
    send(8'h3E);
    chk("after_timeout", head(), ev(8'h3E, 0, 0, 1, 4'd8, 0));
    pop();
    send(8'hE1);
    chk("e1_ignored", 32'(bus.ev_valid), 32'd0);

    send(8'h45);
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    bus.ev_ready = 1'b1;
    send(8'h3D);
    bus.ev_ready = 1'b0;
    chk("push_pop_full_count", 32'(bus.fifo_count), 32'd4);
    chk("push_pop_full_ovf", 32'(bus.overflow_sticky), 32'd0);
    chk("push_pop_full_head", head(), ev(8'h16, 0, 0, 1, 4'd1, 0));
    pop();
    pop();
    pop();
    chk("tail_3d", head(), ev(8'h3D, 0, 0, 1, 4'd7, 0));
    pop();

    send(8'h45);
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    bus.clear_overflow = 1'b1;
    send(8'h25);
    bus.clear_overflow = 1'b0;
    chk("set_beats_clear", 32'(bus.overflow_sticky), 32'd1);
    repeat (4) pop();
    chk("empty_again", 32'(bus.fifo_count), 32'd0);

    send(8'h16);
    send(8'hE0);
    #2 reset_neg = 1'b0;
    #2;
    chk("midreset_head", head(), 32'd0);
    chk("midreset_count", 32'(bus.fifo_count), 32'd0);
    chk("midreset_ovf", 32'(bus.overflow_sticky), 32'd0);
    reset_neg = 1'b1;
    tick();
    send(8'h75);
    chk("after_reset_75", head(), ev(8'h75, 0, 0, 1, 4'd8, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
